// File: rtl/serial_logic_unit.sv
// -----------------------------------------------------------------------------
// serial_logic_unit
//
// Bit-serial logic/arithmetic unit. On an accepted start the two operands and
// the opcode are latched. One bit pair per clock, LSB first, then goes through
// a 1-bit function cell (AND / OR / XOR / full-add). The completed word is
// copied to a registered result together with carry and zero flags.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset, has priority over start
//   start      begin an operation; sampled only in IDLE or DONE
//   op         00 AND, 01 OR, 10 XOR, 11 ADD
//   a, b       WIDTH-bit operands, latched on an accepted start
//   busy       high while bits are being processed (RUN)
//   done       one-cycle pulse; result/flags are valid from this cycle on
//   result     registered result of the last completed operation
//   carry_out  final carry of ADD; 0 for the logic ops
//   zero       high when result == 0
// -----------------------------------------------------------------------------
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_ADD} op_t;

  state_t           state, state_nxt;
  op_t              sop;
  logic [WIDTH-1:0] sa, sb, wres, wres_nxt;
  logic [CW-1:0]    cnt;
  logic             c, c_nxt, bit_out;
  logic             last_bit, accept;

  // ---------------------------------------------------------------------------
  // 1-bit function cell on the current LSBs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    bit_out = 1'b0;
    c_nxt   = 1'b0;
    case (sop)
      OP_AND:  bit_out = sa[0] & sb[0];
      OP_OR:   bit_out = sa[0] | sb[0];
      OP_XOR:  bit_out = sa[0] ^ sb[0];
      OP_ADD: begin
        bit_out = sa[0] ^ sb[0] ^ c;
        c_nxt   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
      end
      default: bit_out = 1'b0;
    endcase
  end

  // New bit enters at the MSB; after WIDTH shifts the LSB-first stream sits in
  // its natural bit positions.
  assign wres_nxt = {bit_out, wres[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = start && (state != RUN);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;  // back-to-back start allowed
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: working shift registers and the visible result registers.
  // The visible outputs move only on the completion edge or on reset, so the
  // working register never shows through during RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here is small control/datapath state and is
      // cleared, so an aborted operation leaves nothing behind.
      sa        <= '0;
      sb        <= '0;
      sop       <= OP_AND;
      c         <= 1'b0;
      cnt       <= '0;
      wres      <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      sop  <= op_t'(op);
      c    <= 1'b0;
      cnt  <= '0;
      wres <= '0;
    end else if (state == RUN) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      wres <= wres_nxt;
      c    <= c_nxt;
      if (last_bit) begin
        cnt       <= '0;
        result    <= wres_nxt;
        carry_out <= (sop == OP_ADD) && c_nxt;
        zero      <= (wres_nxt == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_logic_unit
//
// Scoreboard bench for serial_logic_unit. A reference model tracks the
// handshake as "idle / running with N bits left / done". It computes each
// accepted operation's answer with whole-word arithmetic and queues it. A
// monitor on the falling edge checks busy/done every cycle, pops and compares
// on done, and checks that the outputs hold their last value otherwise.
// -----------------------------------------------------------------------------
module tb_serial_logic_unit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, carry_out, zero;
  logic [WIDTH-1:0] result;

  serial_logic_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;

  exp_t    exp_q[$];
  mphase_t m_phase = M_IDLE;
  int      m_left  = 0;
  exp_t    m_cur   = '{result: '0, carry: 1'b0, zero: 1'b0};
  exp_t    m_held  = '{result: '0, carry: 1'b0, zero: 1'b0};
  bit      checking = 1'b0;
  int      vectors  = 0;
  int      miscompares = 0;

  // Whole-word reference for one operation.
  function automatic exp_t ref_op(input logic [1:0] o,
                                  input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    exp_t e;
    case (o)
      2'b00:   s = {1'b0, x & y};
      2'b01:   s = {1'b0, x | y};
      2'b10:   s = {1'b0, x ^ y};
      default: s = {1'b0, x} + {1'b0, y};
    endcase
    e.result = s[WIDTH-1:0];
    e.carry  = s[WIDTH];
    e.zero   = (s[WIDTH-1:0] == '0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model of the handshake, stepped on the same edge as the DUT.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      // An operation in flight is aborted and will never produce done.
      if (m_phase == M_RUN && exp_q.size() > 0) void'(exp_q.pop_back());
      m_phase <= M_IDLE;
      m_left  <= 0;
      m_held  <= '{result: '0, carry: 1'b0, zero: 1'b0};
    end else if (m_phase != M_RUN && start) begin
      e = ref_op(op, a, b);
      exp_q.push_back(e);
      m_cur   <= e;
      m_phase <= M_RUN;
      m_left  <= WIDTH;
    end else if (m_phase == M_RUN) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_phase <= M_DONE;
        m_held  <= m_cur;
      end
    end else begin
      m_phase <= M_IDLE;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      check("busy", 32'(busy), 32'(m_phase == M_RUN));
      check("done", 32'(done), 32'(m_phase == M_DONE));
      if (done) begin
        check("expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result",    32'(result),    32'(e.result));
          check("carry_out", 32'(carry_out), 32'(e.carry));
          check("zero",      32'(zero),      32'(e.zero));
        end
      end else begin
        check("result_hold", 32'(result),    32'(m_held.result));
        check("carry_hold",  32'(carry_out), 32'(m_held.carry));
        check("zero_hold",   32'(zero),      32'(m_held.zero));
      end
    end
  end

  // Called at a falling edge: present one start for a single cycle, then
  // scramble the operand inputs so late changes would be noticed.
  task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    checking = 1'b1;

    // Directed operations with idle gaps.
    start_op(2'b00, 8'hF0, 8'h3C); repeat (WIDTH + 1) @(negedge clk);
    start_op(2'b11, 8'hFF, 8'h01); repeat (WIDTH + 1) @(negedge clk);
    start_op(2'b11, 8'h5A, 8'h27); repeat (WIDTH + 1) @(negedge clk);
    start_op(2'b10, 8'hA5, 8'hA5); repeat (WIDTH + 1) @(negedge clk);
    start_op(2'b01, 8'h0F, 8'h30); repeat (WIDTH + 1) @(negedge clk);

    // start held high through RUN with operands changing every cycle.
    for (int i = 0; i < 3 * (WIDTH + 1); i++) begin
      start = 1'b1;
      op    = 2'($urandom);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);

    // Back-to-back: second start presented during the DONE cycle.
    start_op(2'b00, 8'hFF, 8'h81);
    repeat (WIDTH) @(negedge clk);
    start_op(2'b11, 8'h01, 8'h01);
    repeat (WIDTH + 1) @(negedge clk);

    // Reset during the 4th RUN cycle, then a normal operation.
    start_op(2'b11, 8'h7E, 8'h11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    start_op(2'b11, 8'h33, 8'h44);
    repeat (WIDTH + 1) @(negedge clk);

    // Random traffic including occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (2 * (WIDTH + 2)) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
Bit-serial logic/arithmetic unit built around the 1-bit AND gate and its sibling gate cells. It is the stage directly downstream of those gates. The block latches two WIDTH-bit operands and an opcode, then streams one bit pair per clock, LSB first, through a 1-bit function cell (AND/OR/XOR/full-add). It produces a registered WIDTH-bit result with carry and zero flags, and uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  single system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE or DONE
op  input  2  function select: 00 AND, 01 OR, 10 XOR, 11 ADD
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
busy  output  1  high while bits are being processed (RUN state)
done  output  1  one-cycle pulse; result/flags valid from this cycle onward
result  output  WIDTH  registered result of last completed operation
carry_out  output  1  final carry of ADD; 0 for logic ops
zero  output  1  high when result == 0

Behaviour:
- Reset:
  - Applies on any clk edge with rst=1, regardless of state, including mid-RUN.
  - State goes to IDLE; busy, done, result, carry_out and zero all go to 0.
  - Internal shift registers, bit counter and carry are cleared.
  - An aborted operation never produces done.
  - rst has priority over start.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch a, b, op into working shift registers; clear carry and bit counter; go to RUN.
- RUN:
  - busy=1.
  - Each edge:
    - bit = f(sa[0], sb[0], c), where AND/OR/XOR ignore c.
    - ADD: bit = sa^sb^c; c_next = majority(sa, sb, c).
    - Shift sa and sb right by 1.
    - Shift bit into the MSB of the working result register.
    - Increment the counter.
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1):
    - Copy the completed working result to result.
    - Set carry_out = (op==ADD) ? c_next : 0.
    - Set zero = (completed result == 0).
    - Go to DONE.
  - start is ignored in RUN; the operands and op in flight are unaffected.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - Next edge: start=1 behaves as an accepted start from IDLE (back-to-back, goes to RUN); otherwise go to IDLE.
- Latency:
  - Accepted start at edge E0.
  - busy high for cycles after E0 through E(WIDTH).
  - done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after start is sampled.
  - Throughput: one operation per WIDTH+1 cycles.
- Output stability:
  - result, carry_out and zero change only on the completion edge or on reset.
  - During RUN they hold the previous operation's values. The working register is never visible on the outputs.
- Width rules:
  - ADD is modulo 2^WIDTH; overflow is reported only via carry_out.
  - No signed overflow flag.
- Counter: ceil(log2(WIDTH)) bits wide; wraps to 0 on completion.
- a, b and op may change freely after the accepted start edge without effect.

Test Plan:
- AND: WIDTH=8, rst 2 cycles, start with op=00, a=8'hF0, b=8'h3C → busy for 8 cycles; done pulse 9 edges after start; result=8'h30, carry_out=0, zero=0.
- ADD with carry: op=11, a=8'hFF, b=8'h01 → result=8'h00, carry_out=1, zero=1. Then a=8'h5A, b=8'h27 → result=8'h81, carry_out=0, zero=0.
- XOR/OR: op=10, a=b=8'hA5 → result=8'h00, zero=1. op=01, a=8'h0F, b=8'h30 → result=8'h3F.
- Ignored start: hold start high during RUN with changing a/b → exactly one done per accepted start. Result matches the operands latched at acceptance; busy never drops early.
- Back-to-back: assert start during the DONE cycle (AND 8'hFF, 8'h81 then ADD 8'h01, 8'h01) → second RUN begins without an IDLE cycle. Results 8'h81 then 8'h02; previous result holds during the second RUN.
- Reset mid-operation: rst=1 at the 4th RUN cycle → next edge busy=0, done=0, result=0, state IDLE. No done pulse follows; a subsequent start completes normally.
